// File: rtl/alu_result_queue.sv
// alu_result_queue: execute-to-writeback buffer behind the 32-bit ALU.
// Each accepted ALU output is classified from its control code. Arithmetic
// and compare/set ops are condensed to {result, dest, cond, is_cmp} and
// queued in a small FIFO. NOP and undefined codes are dropped and counted.
module alu_result_queue #(
    parameter int N     = 32,
    parameter int DEPTH = 4,
    parameter int RW    = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [5:0]               in_control,
    input  logic [N-1:0]             in_result,
    input  logic [12:0]              in_flags,
    input  logic [RW-1:0]            in_dest,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [N-1:0]             out_result,
    output logic [RW-1:0]            out_dest,
    output logic                     out_cond,
    output logic                     out_is_cmp,
    output logic                     last_cond,
    output logic [$clog2(DEPTH):0]   count,
    output logic [7:0]               drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    localparam logic [1:0] ST_EMPTY   = 2'd0;
    localparam logic [1:0] ST_PARTIAL = 2'd1;
    localparam logic [1:0] ST_FULL    = 2'd2;

    // Arithmetic/logic codes whose result is written back as-is.
    function automatic logic is_arith(input logic [5:0] c);
        case (c)
            6'b000001, 6'b000010, 6'b000100,
            6'b000101, 6'b000110, 6'b000111: return 1'b1;
            default:                         return 1'b0;
        endcase
    endfunction

    // Compare/set codes occupy the contiguous range 001100..011000.
    function automatic logic is_cmp_op(input logic [5:0] c);
        return (c >= 6'b001100) && (c <= 6'b011000);
    endfunction

    // Drop counter holds at its maximum instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic [1:0]    state, state_nxt;
    logic [CW-1:0] count_nxt;
    logic [AW-1:0] wr_ptr, rd_ptr;

    logic [N-1:0]  mem_result [DEPTH];
    logic [RW-1:0] mem_dest   [DEPTH];
    logic          mem_cond   [DEPTH];
    logic          mem_cmp    [DEPTH];

    logic          arith_p0, cmp_p0, cond_p0;
    logic [N-1:0]  result_p0;
    logic          accept, push, drop, pop;

    // ---- stage p0: decode of the incoming ALU beat ----
    assign arith_p0  = is_arith(in_control);
    assign cmp_p0    = is_cmp_op(in_control);
    assign cond_p0   = cmp_p0 ? (|in_flags) : (in_result == '0);
    assign result_p0 = cmp_p0 ? {{(N-1){1'b0}}, cond_p0} : in_result;

    assign accept = in_valid && in_ready;
    assign push   = accept && (arith_p0 || cmp_p0);
    assign drop   = accept && !(arith_p0 || cmp_p0);
    assign pop    = out_valid && out_ready;

    // Handshake flags come straight from the registered state, so a pop
    // never raises in_ready in the same cycle.
    assign in_ready  = (state != ST_FULL);
    assign out_valid = (state != ST_EMPTY);

    // Next occupancy and the state it implies.
    always_comb begin
        count_nxt = count;
        state_nxt = state;
        case ({push, pop})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
        if (count_nxt == '0)
            state_nxt = ST_EMPTY;
        else if (count_nxt == CNT_FULL)
            state_nxt = ST_FULL;
        else
            state_nxt = ST_PARTIAL;
    end

    // ---- stage p1: queue control state ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_EMPTY;
            count     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            last_cond <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (push && cmp_p0)
                last_cond <= cond_p0;
            if (drop)
                drop_cnt <= sat_inc8(drop_cnt);
        end
    end

    // Entry storage; contents are only meaningful between rd_ptr and wr_ptr.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_result[wr_ptr] <= result_p0;
            mem_dest[wr_ptr]   <= in_dest;
            mem_cond[wr_ptr]   <= cond_p0;
            mem_cmp[wr_ptr]    <= cmp_p0;
        end
    end

    // ---- stage p2: head presentation, forced to zero while empty ----
    assign out_result = out_valid ? mem_result[rd_ptr] : '0;
    assign out_dest   = out_valid ? mem_dest[rd_ptr]   : '0;
    assign out_cond   = out_valid && mem_cond[rd_ptr];
    assign out_is_cmp = out_valid && mem_cmp[rd_ptr];

endmodule

// File: tb/tb_alu_result_queue.sv
// Scoreboard bench for alu_result_queue: the driver pushes the expected
// entry when a keepable op is accepted, a monitor pops and compares on
// every output handshake.
module tb_alu_result_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [5:0]  in_control;
    logic [31:0] in_result;
    logic [12:0] in_flags;
    logic [4:0]  in_dest;
    logic        out_valid, out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_dest;
    logic        out_cond, out_is_cmp, last_cond;
    logic [2:0]  count;
    logic [7:0]  drop_cnt;

    typedef struct packed {
        logic [31:0] r;
        logic [4:0]  d;
        logic        c;
        logic        m;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    alu_result_queue #(.N(32), .DEPTH(4), .RW(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_control(in_control), .in_result(in_result),
        .in_flags(in_flags), .in_dest(in_dest),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_dest(out_dest),
        .out_cond(out_cond), .out_is_cmp(out_is_cmp),
        .last_cond(last_cond), .count(count), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Monitor: compare the head against the scoreboard on each pop.
    always @(negedge clk) begin
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out: got %0h want none", out_result);
            end else begin
                mon_e = sb.pop_front();
                chk("out_result", out_result, mon_e.r);
                chk("out_dest", 32'(out_dest), 32'(mon_e.d));
                chk("out_cond", 32'(out_cond), 32'(mon_e.c));
                chk("out_is_cmp", 32'(out_is_cmp), 32'(mon_e.m));
            end
        end
    end

    // Present one op at posedge+1, hold until accepted, return at posedge+1.
    task automatic send(input logic [5:0] c, input logic [31:0] r, input logic [12:0] f,
                        input logic [4:0] d, input bit keep,
                        input logic [31:0] er, input bit ec, input bit em);
        int n;
        in_valid = 1'b1; in_control = c; in_result = r; in_flags = f; in_dest = d;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got in_ready=0 want 1");
        end
        if (keep) sb.push_back('{r: er, d: d, c: ec, m: em});
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        out_ready = 1'b1;
        n = 0;
        while (count != 0 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        out_ready = 1'b0;
        chk("drain_count", 32'(count), 0);
        chk("sb_empty", 32'(sb.size()), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_control = '0; in_result = '0;
        in_flags = '0; in_dest = '0; out_ready = 1'b0;
        #8;
        chk("rst_count", 32'(count), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_last_cond", 32'(last_cond), 0);
        chk("rst_drop_cnt", 32'(drop_cnt), 0);
        chk("rst_out_result", out_result, 0);
        #4 rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: single arithmetic push, flags ignored, no bypass
        in_valid = 1'b1; in_control = 6'b000001; in_result = 32'h5;
        in_flags = 13'h1FFF; in_dest = 5'd3;
        #2 chk("no_bypass", 32'(out_valid), 0);
        sb.push_back('{r: 32'h5, d: 5'd3, c: 1'b0, m: 1'b0});
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("t1_out_valid", 32'(out_valid), 1);
        chk("t1_out_result", out_result, 32'h5);
        chk("t1_out_dest", 32'(out_dest), 3);
        chk("t1_count", 32'(count), 1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("t1_count_after_pop", 32'(count), 0);
        chk("t1_empty_result", out_result, 0);

        // 2: compare ops, last_cond tracking, zero arithmetic result
        send(6'b001101, 32'hDEAD_BEEF, 13'h0800, 5'd7, 1'b1, 32'h1, 1'b1, 1'b1);
        chk("t2_last_cond_1", 32'(last_cond), 1);
        send(6'b001110, 32'h0000_1234, 13'h0000, 5'd8, 1'b1, 32'h0, 1'b0, 1'b1);
        chk("t2_last_cond_0", 32'(last_cond), 0);
        send(6'b000010, 32'h0, 13'h1FFF, 5'd1, 1'b1, 32'h0, 1'b1, 1'b0);
        chk("t2_last_cond_sticky", 32'(last_cond), 0);
        drain();

        // 3: fill to full, fifth op held until a pop frees space
        send(6'b000100, 32'h11, 13'h0, 5'd11, 1'b1, 32'h11, 1'b0, 1'b0);
        send(6'b000100, 32'h22, 13'h0, 5'd12, 1'b1, 32'h22, 1'b0, 1'b0);
        send(6'b000100, 32'h33, 13'h0, 5'd13, 1'b1, 32'h33, 1'b0, 1'b0);
        send(6'b000100, 32'h44, 13'h0, 5'd14, 1'b1, 32'h44, 1'b0, 1'b0);
        chk("t3_full_count", 32'(count), 4);
        chk("t3_full_in_ready", 32'(in_ready), 0);
        in_valid = 1'b1; in_control = 6'b000100; in_result = 32'h55;
        in_flags = '0; in_dest = 5'd15;
        @(posedge clk); #1;
        chk("t3_held_count", 32'(count), 4);
        out_ready = 1'b1;
        chk("t3_no_comb_ready", 32'(in_ready), 0);
        @(posedge clk); #1;
        chk("t3_after_pop_count", 32'(count), 3);
        chk("t3_after_pop_ready", 32'(in_ready), 1);
        sb.push_back('{r: 32'h55, d: 5'd15, c: 1'b0, m: 1'b0});
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("t3_push_pop_count", 32'(count), 3);
        drain();

        // 4: steady push+pop at count 2 across pointer wrap
        send(6'b000101, 32'hA0, 13'h0, 5'd20, 1'b1, 32'hA0, 1'b0, 1'b0);
        send(6'b000110, 32'hA1, 13'h0, 5'd21, 1'b1, 32'hA1, 1'b0, 1'b0);
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_control = 6'b000111; in_result = 32'hB0 + 32'(i);
            in_flags = '0; in_dest = 5'(i);
            sb.push_back('{r: 32'hB0 + 32'(i), d: 5'(i), c: 1'b0, m: 1'b0});
            @(posedge clk); #1;
            chk("t4_count", 32'(count), 2);
        end
        in_valid = 1'b0;
        drain();

        // 5: filtered codes, including the compare-range neighbours
        send(6'b000000, 32'h1, 13'h0, 5'd1, 1'b0, 32'h0, 1'b0, 1'b0);
        send(6'b111111, 32'h2, 13'h0, 5'd2, 1'b0, 32'h0, 1'b0, 1'b0);
        send(6'b001011, 32'h3, 13'h1, 5'd3, 1'b0, 32'h0, 1'b0, 1'b0);
        send(6'b011001, 32'h4, 13'h1, 5'd4, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("t5_drop_4", 32'(drop_cnt), 4);
        chk("t5_count_0", 32'(count), 0);
        in_valid = 1'b1; in_control = 6'b000011; in_result = 32'h7;
        repeat (300) @(posedge clk);
        #1 in_valid = 1'b0;
        chk("t5_drop_sat", 32'(drop_cnt), 255);
        chk("t5_out_valid", 32'(out_valid), 0);

        // 6: asynchronous reset with entries queued
        send(6'b001100, 32'h0, 13'h0004, 5'd5, 1'b1, 32'h1, 1'b1, 1'b1);
        send(6'b011000, 32'h0, 13'h1000, 5'd6, 1'b1, 32'h1, 1'b1, 1'b1);
        send(6'b000001, 32'h9, 13'h0, 5'd9, 1'b1, 32'h9, 1'b0, 1'b0);
        chk("t6_count_3", 32'(count), 3);
        chk("t6_last_cond", 32'(last_cond), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_out_valid", 32'(out_valid), 0);
        chk("t6_rst_count", 32'(count), 0);
        chk("t6_rst_drop_cnt", 32'(drop_cnt), 0);
        chk("t6_rst_last_cond", 32'(last_cond), 0);
        chk("t6_rst_in_ready", 32'(in_ready), 1);
        sb.delete();
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("t6_post_count", 32'(count), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
